imem_fetch_controller: RTL
==========================

# imem_fetch_controller

Sequences instruction fetch from the combinational, word-indexed instruction memory of the RISC-V datapath. Owns the program counter, drives the memory word address, and captures returned instructions with their PCs into a small in-order buffer. The buffer feeds decode over a valid/ready handshake. Branch and jump redirects flush the buffer and restart fetch at the new target.

## Interface
- RESET_PC, 64'd0, byte address fetched first after reset
- DEPTH, 2, instruction buffer entries; power of two, ≥2

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  64  memory word index = {2'b00, fetch_pc[63:2]}
- imem_data  in  32  instruction at imem_addr, same cycle (combinational memory)
- redirect_valid  in  1  taken branch/jump; overrides everything this cycle
- redirect_pc  in  64  new byte PC; bits [1:0] ignored (forced 0)
- halt  in  1  suppress new captures; buffer still drains
- inst_valid  out  1  buffer head valid
- inst_ready  in  1  decode accepts head
- inst_out  out  32  head instruction
- inst_pc  out  64  byte PC of head instruction
- fetch_pc  out  64  PC currently presented to memory (debug)

## Operation
- State:
  - fetch_pc
  - circular buffer of DEPTH {instr, pc} entries
  - rd_ptr, wr_ptr: log2(DEPTH) bits, wrap modulo DEPTH
  - count: 0..DEPTH
- pop = inst_valid & inst_ready.
- push = !redirect_valid & !halt & (count < DEPTH | pop).
  - Full with simultaneous pop: push allowed.
- On push, at the clock edge:
  - write {imem_data, fetch_pc} at wr_ptr, then wr_ptr++
  - fetch_pc += 4 (64-bit wrap, no overflow flag)
- On pop: rd_ptr++.
- count' = count + push − pop.
- Redirect (highest priority), at the clock edge:
  - count ← 0; rd_ptr ← 0; wr_ptr ← 0
  - fetch_pc ← {redirect_pc[63:2], 2'b00}
  - No capture that cycle.
  - A pop in the same cycle still counts as delivered to decode.
- halt:
  - fetch_pc and wr_ptr frozen.
  - Pops proceed.
  - On deassertion, fetch resumes at the frozen fetch_pc.
- inst_valid = (count != 0).
- inst_out and inst_pc come from entry rd_ptr, and are 0 when count == 0.
- Memory addressing:
  - Memory is indexed in 32-bit words.
  - fetch_pc is a byte address, so imem_addr = fetch_pc >> 2, zero-extended.
- No decode of instructions; no misaligned-fetch exception. Low PC bits are silently cleared.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - fetch_pc = RESET_PC; imem_addr = RESET_PC >> 2
  - count = 0; pointers = 0
  - inst_valid = 0; inst_out = 0; inst_pc = 0
- First edge after rst_n rises: captures mem[RESET_PC>>2]. inst_valid = 1 from that edge.
- Steady state: one instruction per cycle when inst_ready is held high.
- Fetch-to-decode latency: 1 edge.
- Redirect penalty: redirect asserted before edge N.
  - After N: inst_valid = 0, fetch_pc = target.
  - Edge N+1 captures the target; inst_valid = 1 after N+1.
  - Exactly one bubble.
- Backpressure: with inst_ready low, the buffer fills DEPTH entries in DEPTH edges, then fetch_pc holds.
- The head entry and fetch_pc are stable while stalled.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Buffered instructions are discarded.
- Redirect while halt: redirect applies (flush and load PC); no capture until halt deasserts.
- No combinational path from inst_ready or redirect_valid to imem_addr. imem_addr depends only on the fetch_pc register.

## Test plan
- Reset and stream:
  - Stimulus: RESET_PC=0; mem[0]=0x00F00113, mem[1]=0x00A00093, mem[2]=0x002081B3; inst_ready=1.
  - Required: (inst_out, inst_pc) = (0x00F00113, 0), (0x00A00093, 4), (0x002081B3, 8) on consecutive cycles; no bubbles.
- Backpressure:
  - Stimulus: inst_ready=0 for 5 cycles after reset, DEPTH=2.
  - Required: count saturates at 2; fetch_pc holds at 8. On release, PCs 0, 4, 8 are delivered in order with no loss or duplication.
- Full with simultaneous pop:
  - Stimulus: count=2, inst_ready=1.
  - Required: count stays 2 and fetch_pc advances by 4 every cycle.
- Redirect:
  - Stimulus: at PC 40, redirect_pc=56 with the buffer holding 2 entries.
  - Required: the buffer is flushed; one cycle with inst_valid=0; next head is inst_pc=56 with inst_out=mem[14].
  - Also: redirect_pc=0x3B (misaligned) → next head inst_pc=0x38.
- Halt:
  - Stimulus: halt=1 for 3 cycles at fetch_pc=12 with inst_ready=1.
  - Required: the buffer drains to inst_valid=0 and fetch_pc stays 12. After halt drops, the next head is inst_pc=12.
- Asynchronous reset mid-stream:
  - Stimulus: rst_n pulsed low between clock edges while count=2.
  - Required: inst_valid=0 and fetch_pc=RESET_PC immediately, without a clock edge. Stream restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_controller_if.sv
// Fetch-side bus of the instruction fetch controller: memory port, redirect/halt
// controls and the valid/ready instruction stream towards decode.
interface imem_fetch_controller_if;
   logic [63:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [63:0] inst_pc;
   logic [63:0] fetch_pc;

   modport master (
      output imem_addr, inst_valid, inst_out, inst_pc, fetch_pc,
      input  imem_data, redirect_valid, redirect_pc, halt, inst_ready
   );

   modport slave (
      input  imem_addr, inst_valid, inst_out, inst_pc, fetch_pc,
      output imem_data, redirect_valid, redirect_pc, halt, inst_ready
   );
endinterface

// File: rtl/imem_fetch_controller.sv
// Instruction fetch controller: owns the PC, addresses a combinational word memory
// and queues {instr, pc} pairs in a small circular buffer feeding decode.
module imem_fetch_controller #(
   parameter logic [63:0] RESET_PC = 64'd0,
   parameter int unsigned DEPTH    = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   imem_fetch_controller_if.master        bus
);
   localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   instr_q [DEPTH];
   logic [31:0]   instr_d [DEPTH];
   logic [63:0]   pc_q    [DEPTH];
   logic [63:0]   pc_d    [DEPTH];
   logic          pop;
   logic          push;
   logic          unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

   always_comb begin
      pop        = (count_q != '0) & bus.inst_ready;
      // a full buffer may still capture when the head leaves in the same cycle
      push       = ~bus.redirect_valid & ~bus.halt & ((count_q < FULL) | pop);
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = {bus.redirect_pc[63:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            instr_d[wr_ptr_q] = bus.imem_data;
            pc_d[wr_ptr_q]    = fetch_pc_q;
            wr_ptr_d          = wr_ptr_q + 1'b1;
            fetch_pc_d        = fetch_pc_q + 64'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
      end
   end

   // memory address is a pure function of the PC register
   always_comb begin
      bus.imem_addr  = {2'b00, fetch_pc_q[63:2]};
      bus.fetch_pc   = fetch_pc_q;
      bus.inst_valid = (count_q != '0);
      bus.inst_out   = (count_q != '0) ? instr_q[rd_ptr_q] : '0;
      bus.inst_pc    = (count_q != '0) ? pc_q[rd_ptr_q]    : '0;
   end
endmodule
